// File: rtl/calc1_req_driver_if.sv
// Bundle of the host, calc1 and result handshake signals for calc1_req_driver.
// slave modport: the driver itself. master modport: the environment around it
// (host, calc1 port and result consumer).
interface calc1_req_driver_if;
  logic        host_valid;
  logic        host_ready;
  logic [0:3]  host_cmd;
  logic [0:31] host_op1;
  logic [0:31] host_op2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  calc_resp;
  logic [0:31] calc_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        rsp_timeout;

  modport slave (
    input  host_valid, host_cmd, host_op1, host_op2,
    input  calc_resp, calc_data, rsp_ready,
    output host_ready, req_cmd_out, req_data_out,
    output rsp_valid, rsp_code, rsp_data, rsp_timeout
  );

  modport master (
    output host_valid, host_cmd, host_op1, host_op2,
    output calc_resp, calc_data, rsp_ready,
    input  host_ready, req_cmd_out, req_data_out,
    input  rsp_valid, rsp_code, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/calc1_req_driver.sv
// calc1_req_driver: takes one operation (cmd, op1, op2) from a host, drives it
// onto a calc1 port as two request cycles, waits up to TIMEOUT cycles for the
// response and presents the result on a valid/ready handshake.
// Ports:
//   c_clk      rising-edge clock
//   reset_n    synchronous active-low reset
//   bus        calc1_req_driver_if.slave (host, calc1 request/response, result)
//   stray_err  sticky flag for responses outside WAIT (only with
//              CALC1_DRV_STRAY_CHK_EN defined)
// Optional feature macro: CALC1_DRV_STRAY_CHK_EN.
module calc1_req_driver #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               c_clk,
  input  logic               reset_n,
  calc1_req_driver_if.slave  bus
`ifdef CALC1_DRV_STRAY_CHK_EN
  ,
  output logic               stray_err
`endif
);

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP1  = 3'd1,
    S_OP2  = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [0:CMD_W-1]  req_cmd_q,  req_cmd_d;
  logic [0:DATA_W-1] req_data_q, req_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [0:RESP_W-1] rsp_code_q, rsp_code_d;
  logic [0:DATA_W-1] rsp_data_q, rsp_data_d;
  logic              rsp_to_q,   rsp_to_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [0:DATA_W-1] op2_q,      op2_d;

  logic resp_seen;
  logic wait_last;

  assign resp_seen = (bus.calc_resp != '0);
  assign wait_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge c_clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.host_valid) state_d = (bus.host_cmd != '0) ? S_OP1 : S_HOLD;
      S_OP1:  state_d = S_OP2;
      S_OP2:  state_d = S_WAIT;
      S_WAIT: if (resp_seen || wait_last) state_d = S_HOLD;
      S_HOLD: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, counter and op2.
  // cmd/op1 go straight into the request registers at accept so they are on
  // the bus in the first cycle after the accept edge; only op2 must be held.
  always_comb begin
    req_cmd_d   = '0;
    req_data_d  = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_code_d  = rsp_code_q;
    rsp_data_d  = rsp_data_q;
    rsp_to_d    = rsp_to_q;
    cnt_d       = cnt_q;
    op2_d       = op2_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.host_valid) begin
          if (bus.host_cmd != '0) begin
            req_cmd_d  = bus.host_cmd;
            req_data_d = bus.host_op1;
            op2_d      = bus.host_op2;
          end else begin
            // Command 0 is rejected locally without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_code_d  = RESP_W'(2);
            rsp_data_d  = '0;
            rsp_to_d    = 1'b0;
          end
        end
      end
      S_OP1: begin
        req_data_d = op2_q;
      end
      S_OP2: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        if (resp_seen) begin
          rsp_valid_d = 1'b1;
          rsp_code_d  = bus.calc_resp;
          rsp_data_d  = bus.calc_data;
          rsp_to_d    = 1'b0;
        end else if (wait_last) begin
          rsp_valid_d = 1'b1;
          rsp_code_d  = '0;
          rsp_data_d  = '0;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output, counter and operand registers
  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      req_cmd_q   <= '0;
      req_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= '0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
      cnt_q       <= '0;
      op2_q       <= '0;
    end else begin
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
      cnt_q       <= cnt_d;
      op2_q       <= op2_d;
    end
  end

  assign bus.host_ready   = reset_n && (state_q == S_IDLE);
  assign bus.req_cmd_out  = req_cmd_q;
  assign bus.req_data_out = req_data_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_code     = rsp_code_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_timeout  = rsp_to_q;

`ifdef CALC1_DRV_STRAY_CHK_EN
  // Sticky flag for a calc1 response arriving while no request is outstanding.
  always_ff @(posedge c_clk) begin
    if (!reset_n)                            stray_err <= 1'b0;
    else if (resp_seen && state_q != S_WAIT) stray_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_calc1_req_driver.sv
// Self-checking bench for calc1_req_driver (TIMEOUT = 8): directed vector
// table, a reset-mid-WAIT sequence and randomized operations checked against
// a transaction-level expectation model.
module tb_calc1_req_driver;

  localparam int unsigned TO = 8;

  logic c_clk;
  logic reset_n;
  int   checks;
  int   errors;
  string cur_tag;

  calc1_req_driver_if intf ();

`ifdef CALC1_DRV_STRAY_CHK_EN
  logic stray_err;
  calc1_req_driver #(.TIMEOUT(TO)) dut (
    .c_clk(c_clk), .reset_n(reset_n), .bus(intf.slave), .stray_err(stray_err));
`else
  calc1_req_driver #(.TIMEOUT(TO)) dut (
    .c_clk(c_clk), .reset_n(reset_n), .bus(intf.slave));
`endif

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          dly;   // WAIT cycle index at which calc1 answers
    logic [1:0]  rc;
    logic [31:0] rd;
    int          bp;    // extra HOLD cycles with rsp_ready low; -1 = ready early
    logic [1:0]  ec;
    logic [31:0] ed;
    logic        et;
    int          lat;   // cycles from accept edge to first rsp_valid cycle
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h at %0t", cur_tag, name, act, exp, $time);
    end
  endtask

  // Expected outcome of one operation derived from the protocol rules.
  function automatic void model(input logic [3:0] cmd, input int dly,
                                input logic [1:0] rc, input logic [31:0] rd,
                                output logic [1:0] ec, output logic [31:0] ed,
                                output logic et, output int lat);
    if (cmd == 4'd0) begin
      ec = 2'd2; ed = 32'd0; et = 1'b0; lat = 1;
    end else if (rc != 2'd0 && dly < int'(TO)) begin
      ec = rc; ed = rd; et = 1'b0; lat = 3 + dly + 1;
    end else begin
      ec = 2'd0; ed = 32'd0; et = 1'b1; lat = 3 + int'(TO);
    end
  endfunction

  // Runs one operation; called at a negedge with the driver idle.
  task automatic do_op(input vec_t v);
    int last;
    logic [3:0]  ecmd;
    logic [31:0] edata;
    last = v.lat + ((v.bp > 0) ? v.bp : 0);
    chk("host_ready_idle", 32'(intf.host_ready), 32'd1);
    intf.host_valid = 1'b1;
    intf.host_cmd   = v.cmd;
    intf.host_op1   = v.op1;
    intf.host_op2   = v.op2;
    intf.rsp_ready  = (v.bp < 0);
    intf.calc_resp  = 2'd0;
    @(posedge c_clk);
    #1;
    intf.host_valid = 1'b0;
    intf.host_cmd   = 4'($urandom);
    intf.host_op1   = $urandom;
    intf.host_op2   = $urandom;
    for (int n = 1; n <= last; n++) begin
      @(negedge c_clk);
      ecmd  = (n == 1 && v.cmd != 4'd0) ? v.cmd : 4'd0;
      edata = (v.cmd == 4'd0) ? 32'd0 : (n == 1) ? v.op1 : (n == 2) ? v.op2 : 32'd0;
      chk("req_cmd_out", 32'(intf.req_cmd_out), 32'(ecmd));
      chk("req_data_out", 32'(intf.req_data_out), edata);
      chk("rsp_valid", 32'(intf.rsp_valid), 32'(n >= v.lat));
      chk("host_ready_busy", 32'(intf.host_ready), 32'd0);
      if (n >= v.lat) begin
        chk("rsp_code", 32'(intf.rsp_code), 32'(v.ec));
        chk("rsp_data", 32'(intf.rsp_data), v.ed);
        chk("rsp_timeout", 32'(intf.rsp_timeout), 32'(v.et));
      end
      if (v.cmd != 4'd0 && n >= 3 && n < v.lat) begin
        intf.calc_resp = (n - 3 == v.dly) ? v.rc : 2'd0;
        intf.calc_data = (n - 3 == v.dly) ? v.rd : $urandom;
      end else begin
        // Outside WAIT calc1 activity must be ignored.
        intf.calc_resp = 2'($urandom);
        intf.calc_data = $urandom;
      end
      if (v.bp >= 0) intf.rsp_ready = (n == last);
    end
    @(negedge c_clk);
    intf.rsp_ready = 1'b0;
    intf.calc_resp = 2'd0;
    chk("host_ready_after", 32'(intf.host_ready), 32'd1);
    chk("rsp_valid_after", 32'(intf.rsp_valid), 32'd0);
  endtask

  task automatic chk_idle_outputs();
    chk("req_cmd_zero", 32'(intf.req_cmd_out), 32'd0);
    chk("req_data_zero", intf.req_data_out, 32'd0);
    chk("rsp_valid_zero", 32'(intf.rsp_valid), 32'd0);
    chk("rsp_code_zero", 32'(intf.rsp_code), 32'd0);
    chk("rsp_data_zero", intf.rsp_data, 32'd0);
    chk("rsp_timeout_zero", 32'(intf.rsp_timeout), 32'd0);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    cur_tag = "reset";
    reset_n = 1'b0;
    intf.host_valid = 1'b0;
    intf.host_cmd   = 4'd0;
    intf.host_op1   = 32'd0;
    intf.host_op2   = 32'd0;
    intf.calc_resp  = 2'd0;
    intf.calc_data  = 32'd0;
    intf.rsp_ready  = 1'b0;

    //                 cmd    op1           op2           dly rc  rd            bp  ec  ed            et  lat
    tbl[0] = '{4'd1,  32'h0000_0001, 32'h1FFF_FFFF, 0,  2'd1, 32'h2000_0000, 0,  2'd1, 32'h2000_0000, 1'b0, 4};
    tbl[1] = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 2,  2'd2, 32'h0000_0000, 0,  2'd2, 32'h0000_0000, 1'b0, 6};
    tbl[2] = '{4'd3,  32'h1234_5678, 32'h9ABC_DEF0, 1,  2'd2, 32'h0000_0000, -1, 2'd2, 32'h0000_0000, 1'b0, 5};
    tbl[3] = '{4'd0,  32'hDEAD_BEEF, 32'hCAFE_F00D, 0,  2'd1, 32'h1111_1111, 0,  2'd2, 32'h0000_0000, 1'b0, 1};
    tbl[4] = '{4'd5,  32'hA5A5_A5A5, 32'h5A5A_5A5A, 99, 2'd0, 32'h0000_0000, 0,  2'd0, 32'h0000_0000, 1'b1, 11};
    tbl[5] = '{4'd2,  32'h0000_0007, 32'h0000_0009, 3,  2'd1, 32'h0000_BEEF, 10, 2'd1, 32'h0000_BEEF, 1'b0, 7};
    tbl[6] = '{4'd4,  32'h0000_0001, 32'h0000_0002, 7,  2'd3, 32'h0F0F_0F0F, 0,  2'd3, 32'h0F0F_0F0F, 1'b0, 11};
    tbl[7] = '{4'd4,  32'h0000_0001, 32'h0000_0002, 8,  2'd1, 32'h0001_2345, 0,  2'd0, 32'h0000_0000, 1'b1, 11};
    tbl[8] = '{4'd15, 32'h8000_0000, 32'h7FFF_FFFF, 0,  2'd2, 32'h0000_0000, 1,  2'd2, 32'h0000_0000, 1'b0, 4};

    repeat (2) @(negedge c_clk);
    chk_idle_outputs();
    chk("host_ready_in_reset", 32'(intf.host_ready), 32'd0);
`ifdef CALC1_DRV_STRAY_CHK_EN
    chk("stray_err_reset", 32'(stray_err), 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge c_clk);
    chk("host_ready_out_of_reset", 32'(intf.host_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_op(tbl[i]);
    end

    // Reset in the middle of WAIT, then a late calc1 response while idle.
    cur_tag = "reset_mid_wait";
    intf.host_valid = 1'b1;
    intf.host_cmd   = 4'd2;
    intf.host_op1   = 32'h0000_00AA;
    intf.host_op2   = 32'h0000_00BB;
    @(posedge c_clk);
    #1;
    intf.host_valid = 1'b0;
    repeat (4) @(negedge c_clk);
    reset_n = 1'b0;
    #1;
    chk("host_ready_reset_low", 32'(intf.host_ready), 32'd0);
    @(negedge c_clk);
    chk_idle_outputs();
`ifdef CALC1_DRV_STRAY_CHK_EN
    chk("stray_err_cleared", 32'(stray_err), 32'd0);
`endif
    reset_n = 1'b1;
    intf.calc_resp = 2'd1;
    intf.calc_data = 32'h5555_AAAA;
    #1;
    chk("host_ready_after_reset", 32'(intf.host_ready), 32'd1);
    @(negedge c_clk);
    intf.calc_resp = 2'd0;
`ifdef CALC1_DRV_STRAY_CHK_EN
    chk("stray_err_set", 32'(stray_err), 32'd1);
`endif
    for (int i = 0; i < 12; i++) begin
      chk_idle_outputs();
      chk("host_ready_idle_hold", 32'(intf.host_ready), 32'd1);
      @(negedge c_clk);
    end

    // Randomized operations against the expectation model.
    for (int i = 0; i < 40; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      v.cmd = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      v.op1 = $urandom;
      v.op2 = $urandom;
      v.dly = $urandom_range(0, TO + 2);
      v.rc  = 2'($urandom);
      v.rd  = $urandom;
      case ($urandom_range(0, 2))
        0:       v.bp = -1;
        1:       v.bp = 0;
        default: v.bp = $urandom_range(1, 4);
      endcase
      model(v.cmd, v.dly, v.rc, v.rd, v.ec, v.ed, v.et, v.lat);
      do_op(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
